// File: rtl/rx_fir_pkg.sv
// rx_fir_pkg: shared widths, tap count, FSM encoding and pipeline depth for the receive band-pass FIR
package rx_fir_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int N_TAPS     = 2 ** ADDR_W;
    localparam int ACC_W      = 41;
    localparam int OUT_SHIFT  = 15;
    localparam int PIPE_DEPTH = 3;
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/rx_fir_mac.sv
// rx_fir_mac: registered multiply, sign-extended accumulate and saturating output register
//   clk/rst    clock, async active-high reset
//   i_clr      zero the accumulator
//   i_en       i_a/i_b hold a valid coefficient/sample pair this cycle
//   i_load     capture saturate(acc >>> OUT_SHIFT) into o_y
//   o_y        filtered sample, holds between loads
module rx_fir_mac #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 41,
    parameter int OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    input  logic                     i_load,
    output logic signed [DATA_W-1:0] o_y
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_prod_vld;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    w_shf;
    logic signed [DATA_W-1:0]   w_sat;
    assign w_shf = r_acc >>> OUT_SHIFT;
    assign w_sat = (w_shf > SAT_MAX) ? DATA_W'(SAT_MAX) :
                   (w_shf < SAT_MIN) ? DATA_W'(SAT_MIN) : DATA_W'(w_shf);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            o_y        <= '0;
        end else begin
            r_prod     <= (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
            r_prod_vld <= i_en;
            r_acc      <= i_clr ? '0 :
                          r_prod_vld ? r_acc + {{(ACC_W-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod} : r_acc;
            o_y        <= i_load ? w_sat : o_y;
        end
    end
endmodule

// File: rtl/rx_band_pass_fir_ctrl.sv
// rx_band_pass_fir_ctrl: sequencer and MAC for the 512-tap receive band-pass FIR
//   rrx_rst                        async active-high reset; buffer is zeroed (CLEAR) afterwards
//   smp_in_valid/smp_in            input samples; busy/overrun report drops
//   filt_valid/filt_out            one filtered, saturated sample per accepted input
//   cfg_we/cfg_addr/cfg_data       coefficient reload, rejected with cfg_err while busy
//   coef_* / smp_*                 coefficient BRAM and circular sample buffer ports (1-cycle read latency)
module rx_band_pass_fir_ctrl #(
    parameter int DATA_W    = rx_fir_pkg::DATA_W,
    parameter int ADDR_W    = rx_fir_pkg::ADDR_W,
    parameter int ACC_W     = rx_fir_pkg::ACC_W,
    parameter int OUT_SHIFT = rx_fir_pkg::OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     rrx_rst,
    input  logic                     smp_in_valid,
    input  logic signed [DATA_W-1:0] smp_in,
    output logic                     busy,
    output logic                     overrun,
    output logic                     filt_valid,
    output logic signed [DATA_W-1:0] filt_out,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    output logic                     cfg_err,
    output logic                     coef_ena,
    output logic                     coef_wea,
    output logic [ADDR_W-1:0]        coef_addra,
    output logic signed [DATA_W-1:0] coef_dia,
    output logic                     coef_enb,
    output logic [ADDR_W-1:0]        coef_addrb,
    input  logic signed [DATA_W-1:0] coef_dob,
    output logic                     smp_we,
    output logic [ADDR_W-1:0]        smp_waddr,
    output logic signed [DATA_W-1:0] smp_wdata,
    output logic                     smp_re,
    output logic [ADDR_W-1:0]        smp_raddr,
    input  logic signed [DATA_W-1:0] smp_rdata
);
    import rx_fir_pkg::*;
    state_t            r_state, w_nxt;
    logic [ADDR_W-1:0] r_cnt, r_wptr;
    logic              r_rd_vld, r_ovr, r_cfg_err;
    logic              w_clr, w_open, w_acc, w_cfg, w_rd, w_busy, w_cnt_end, w_drn_end;
    // CLEAR is the reset state, so its strobes are masked while reset is held to keep outputs at 0
    assign w_clr     = (r_state == S_CLEAR) && !rrx_rst;
    // DONE accepts like IDLE so back-to-back samples sustain one result per 516 cycles
    assign w_open    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_acc     = w_open && smp_in_valid;
    assign w_cfg     = w_open && cfg_we && !smp_in_valid;
    assign w_rd      = (r_state == S_RUN);
    assign w_busy    = w_clr || w_rd || (r_state == S_DRAIN);
    assign w_cnt_end = &r_cnt;
    assign w_drn_end = (r_cnt == ADDR_W'(PIPE_DEPTH - 1));
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_CLEAR: w_nxt = w_cnt_end ? S_IDLE : S_CLEAR;
            S_IDLE:  w_nxt = smp_in_valid ? S_RUN : S_IDLE;
            S_RUN:   w_nxt = w_cnt_end ? S_DRAIN : S_RUN;
            S_DRAIN: w_nxt = w_drn_end ? S_DONE : S_DRAIN;
            S_DONE:  w_nxt = smp_in_valid ? S_RUN : S_IDLE;
            default: w_nxt = S_CLEAR;
        endcase
    end
    always_ff @(posedge clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            r_state   <= S_CLEAR;
            r_cnt     <= '0;
            r_wptr    <= '0;
            r_rd_vld  <= 1'b0;
            r_ovr     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= (w_nxt != r_state) ? '0 :
                         (r_state inside {S_CLEAR, S_RUN, S_DRAIN}) ? r_cnt + 1'b1 : r_cnt;
            r_wptr    <= (r_state == S_DRAIN && w_drn_end) ? r_wptr + 1'b1 : r_wptr;
            r_rd_vld  <= w_rd;
            r_ovr     <= smp_in_valid && w_busy;
            r_cfg_err <= cfg_we && (w_busy || w_acc);
        end
    end
    assign busy       = w_busy;
    assign overrun    = r_ovr;
    assign cfg_err    = r_cfg_err;
    assign filt_valid = (r_state == S_DONE);
    assign smp_we     = w_clr || w_acc;
    assign smp_waddr  = w_clr ? r_cnt : w_acc ? r_wptr : '0;
    assign smp_wdata  = w_acc ? smp_in : '0;
    assign coef_ena   = w_cfg;
    assign coef_wea   = w_cfg;
    assign coef_addra = w_cfg ? cfg_addr : '0;
    assign coef_dia   = w_cfg ? cfg_data : '0;
    assign coef_enb   = w_rd;
    assign smp_re     = w_rd;
    assign coef_addrb = w_rd ? r_cnt : '0;
    // newest sample pairs with tap 0; the 9-bit subtraction wraps the circular buffer
    assign smp_raddr  = w_rd ? r_wptr - r_cnt : '0;
    rx_fir_mac #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst    (rrx_rst),
        .i_clr  (w_acc),
        .i_en   (r_rd_vld),
        .i_a    (coef_dob),
        .i_b    (smp_rdata),
        .i_load (r_state == S_DRAIN && w_drn_end),
        .o_y    (filt_out)
    );
endmodule

// File: tb/tb_rx_band_pass_fir_ctrl.sv
// tb_rx_band_pass_fir_ctrl: directed bench with BRAM models for the FIR controller
module tb_rx_band_pass_fir_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        smp_in_valid = 1'b0, cfg_we = 1'b0;
    logic [15:0] smp_in = '0, cfg_data = '0;
    logic [8:0]  cfg_addr = '0;
    logic        busy, overrun, filt_valid, cfg_err, coef_ena, coef_wea, coef_enb, smp_we, smp_re;
    logic [15:0] filt_out, coef_dia, smp_wdata;
    logic [8:0]  coef_addra, coef_addrb, smp_waddr, smp_raddr;
    logic [15:0] coef_dob = '0, smp_rdata = '0;
    logic [15:0] coef_mem [512];
    logic [15:0] smp_mem [512];
    logic [92:0] all_out;
    int          vectors = 0, miss = 0, n_fv = 0, n_wea = 0, nfv_saved;
    logic        s_valid = 1'b0;
    logic [15:0] s_in = '0;
    logic        s_busy, s_ovr, s_fv, s_cerr, s_cena, s_cwea, s_cenb, s_swe, s_sre;
    logic [15:0] s_fo, s_cdia, s_swdata;
    logic [2:0]  s_caddra, s_caddrb, s_swaddr, s_sraddr;

    always #5 clk = ~clk;

    rx_band_pass_fir_ctrl #(.OUT_SHIFT(0)) dut (
        .clk(clk), .rrx_rst(rst), .smp_in_valid(smp_in_valid), .smp_in(smp_in),
        .busy(busy), .overrun(overrun), .filt_valid(filt_valid), .filt_out(filt_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .coef_ena(coef_ena), .coef_wea(coef_wea), .coef_addra(coef_addra), .coef_dia(coef_dia),
        .coef_enb(coef_enb), .coef_addrb(coef_addrb), .coef_dob(coef_dob),
        .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
        .smp_re(smp_re), .smp_raddr(smp_raddr), .smp_rdata(smp_rdata)
    );

    rx_band_pass_fir_ctrl #(.ADDR_W(3), .OUT_SHIFT(0)) dut_s (
        .clk(clk), .rrx_rst(rst), .smp_in_valid(s_valid), .smp_in(s_in),
        .busy(s_busy), .overrun(s_ovr), .filt_valid(s_fv), .filt_out(s_fo),
        .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(16'd0), .cfg_err(s_cerr),
        .coef_ena(s_cena), .coef_wea(s_cwea), .coef_addra(s_caddra), .coef_dia(s_cdia),
        .coef_enb(s_cenb), .coef_addrb(s_caddrb), .coef_dob(16'd0),
        .smp_we(s_swe), .smp_waddr(s_swaddr), .smp_wdata(s_swdata),
        .smp_re(s_sre), .smp_raddr(s_sraddr), .smp_rdata(16'd0)
    );

    assign all_out = {busy, overrun, filt_valid, filt_out, cfg_err, coef_ena, coef_wea, coef_addra,
                      coef_dia, coef_enb, coef_addrb, smp_we, smp_waddr, smp_wdata, smp_re, smp_raddr};

    always @(posedge clk) begin
        if (coef_ena && coef_wea) coef_mem[coef_addra] <= coef_dia;
        if (coef_enb) coef_dob <= coef_mem[coef_addrb];
        if (smp_we) smp_mem[smp_waddr] <= smp_wdata;
        if (smp_re) smp_rdata <= smp_mem[smp_raddr];
        if (filt_valid) n_fv <= n_fv + 1;
        if (coef_wea) n_wea <= n_wea + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [8:0] a);
        smp_in = x;
        smp_in_valid = 1'b1;
        #1;
        chk("accept", {smp_we, smp_waddr, smp_wdata, busy, coef_wea}, {1'b1, a, x, 1'b0, 1'b0});
        @(negedge clk);
        smp_in_valid = 1'b0;
        smp_in = '0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] y, input int n0);
        int n = n0;
        while (!filt_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 516);
        chk(tag, filt_out, y);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) coef_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out, '0);
        chk("reset_outputs_small", {s_busy, s_swe, s_fv}, '0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            chk("clear_walk", {busy, smp_we, smp_waddr, smp_wdata}, {1'b1, 1'b1, 9'(i), 16'h0});
            @(negedge clk);
        end
        chk("clear_done", {busy, smp_we}, 2'b00);
        for (int i = 0; i < 9; i++) begin
            int n;
            s_valid = 1'b1;
            s_in = 16'(i + 1);
            #1;
            chk("small_accept_addr", {s_swe, s_swaddr}, {1'b1, 3'(i)});
            @(negedge clk);
            s_valid = 1'b0;
            n = 1;
            if (i == 7) for (int k = 0; k < 8; k++) begin
                chk("small_raddr_wrap", {s_sre, s_sraddr}, {1'b1, 3'(7 - k)});
                @(negedge clk);
                n++;
            end
            while (!s_fv && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("small_latency", n, 12);
        end
        cfg_we = 1'b1;
        cfg_addr = 9'd1;
        cfg_data = 16'd1;
        #1;
        chk("cfg_write", {coef_ena, coef_wea, coef_addra, coef_dia}, {1'b1, 1'b1, 9'd1, 16'd1});
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        chk("cfg_no_err", cfg_err, 1'b0);
        send(16'd100, 9'd0);
        chk("raddr_k0", {smp_re, smp_raddr, coef_enb, coef_addrb}, {1'b1, 9'd0, 1'b1, 9'd0});
        @(negedge clk);
        chk("raddr_k1_wrap", {smp_re, smp_raddr, coef_enb, coef_addrb}, {1'b1, 9'd511, 1'b1, 9'd1});
        wait_out("impulse_y0", 16'd0, 2);
        send(16'd0, 9'd1);
        wait_out("impulse_y1", 16'd100, 1);
        send(16'd0, 9'd2);
        wait_out("impulse_y2", 16'd0, 1);
        send(16'd0, 9'd3);
        wait_out("impulse_y3", 16'd0, 1);
        for (int i = 0; i < 512; i++) coef_mem[i] = '0;
        coef_mem[0] = 16'd2;
        coef_mem[1] = 16'hfffd;
        coef_mem[2] = 16'd5;
        smp_mem[3] = 16'd10;
        smp_mem[2] = 16'hfffc;
        send(16'd7, 9'd4);
        repeat (9) @(negedge clk);
        smp_in_valid = 1'b1;
        smp_in = 16'h1234;
        #1;
        chk("busy_drop_sample", {busy, smp_we}, 2'b10);
        @(negedge clk);
        smp_in_valid = 1'b0;
        chk("overrun_pulse", overrun, 1'b1);
        repeat (9) @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 9'd0;
        cfg_data = 16'd999;
        #1;
        chk("busy_drop_cfg", {coef_ena, coef_wea}, 2'b00);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1'b1);
        wait_out("mixed_taps", 16'hffdc, 21);
        chk("no_extra_coef_write", n_wea, 1);
        for (int i = 0; i < 512; i++) begin
            coef_mem[i] = 16'h7fff;
            smp_mem[i] = 16'h7fff;
        end
        cfg_we = 1'b1;
        cfg_addr = 9'd5;
        cfg_data = 16'h1111;
        send(16'h7fff, 9'd5);
        cfg_we = 1'b0;
        #1;
        chk("cfg_collide_err", cfg_err, 1'b1);
        wait_out("sat_pos", 16'h7fff, 1);
        for (int i = 0; i < 512; i++) smp_mem[i] = 16'h8000;
        send(16'h8000, 9'd6);
        wait_out("sat_neg", 16'h8000, 1);
        send(16'd1, 9'd7);
        repeat (199) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outputs", all_out, '0);
        nfv_saved = n_fv;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("clear_restart", {busy, smp_we, smp_waddr}, {1'b1, 1'b1, 9'd0});
        repeat (560) @(negedge clk);
        chk("no_valid_after_abort", n_fv, nfv_saved);
        chk("idle_after_reclear", busy, 1'b0);
        send(16'd5, 9'd0);
        wait_out("post_reset", 16'h7fff, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
